// File: rtl/four_bit_1x2_demux_reg_pkg.sv
// Shared constants and pointer encoding for the registered 1-to-2 demux.
package four_bit_1x2_demux_reg_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int NUM_LANES     = 2;

  localparam logic LANE_0 = 1'b0;
  localparam logic LANE_1 = 1'b1;

  typedef enum logic {
    EXPECT_0 = 1'b0,
    EXPECT_1 = 1'b1
  } ptr_state_e;

  function automatic ptr_state_e ptr_flip(input ptr_state_e s);
    return (s == EXPECT_0) ? EXPECT_1 : EXPECT_0;
  endfunction

endpackage

// File: rtl/four_bit_1x2_demux_reg_lane.sv
// One output lane: held word, valid flag and wrap-around accept counter.
module demux_lane_reg
  import four_bit_1x2_demux_reg_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 ack,
  input  logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     q,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] count
);

  // A load wins over a same-cycle ack, so a lane can stream one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
      count <= '0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
      count <= count + 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/four_bit_1x2_demux_reg.sv
// Registered 1-to-2 demux: steers each accepted word into a held lane register,
// chosen by Select or by an alternating pointer that de-interleaves a stream.
module four_bit_1x2_demux_reg
  import four_bit_1x2_demux_reg_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     In,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic                 Select,
  input  logic                 Mode,
  input  logic                 Sync,
  output logic [WIDTH-1:0]     Out_0,
  output logic                 Out_0_valid,
  input  logic                 Out_0_ack,
  output logic [WIDTH-1:0]     Out_1,
  output logic                 Out_1_valid,
  input  logic                 Out_1_ack,
  output logic [CNT_WIDTH-1:0] Count_0,
  output logic [CNT_WIDTH-1:0] Count_1
);

  ptr_state_e ptr_q, ptr_d;
  logic       target;
  logic       accept;

  logic [NUM_LANES-1:0]                ack;
  logic [NUM_LANES-1:0]                load;
  logic [NUM_LANES-1:0]                valid;
  logic [NUM_LANES-1:0][WIDTH-1:0]     q;
  logic [NUM_LANES-1:0][CNT_WIDTH-1:0] count;

  assign ack      = {Out_1_ack, Out_0_ack};
  assign target   = Mode ? logic'(ptr_q) : Select;
  // Readiness only looks at the target lane; the other lane never stalls input.
  assign In_ready = !valid[target] || ack[target];
  assign accept   = In_valid && In_ready;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign load[g] = accept && (target == 1'(g));

    demux_lane_reg #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .ack   (ack[g]),
      .d     (In),
      .q     (q[g]),
      .valid (valid[g]),
      .count (count[g])
    );
  end

  assign Out_0       = q[LANE_0];
  assign Out_1       = q[LANE_1];
  assign Out_0_valid = valid[LANE_0];
  assign Out_1_valid = valid[LANE_1];
  assign Count_0     = count[LANE_0];
  assign Count_1     = count[LANE_1];

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= EXPECT_0;
    else        ptr_q <= ptr_d;
  end

  // Sync beats the toggle; the word accepted alongside Sync already used the old pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (Sync)                ptr_d = EXPECT_0;
    else if (Mode && accept) ptr_d = ptr_flip(ptr_q);
  end

endmodule

// File: tb/tb_four_bit_1x2_demux_reg.sv
// Directed self-checking bench for the registered 1-to-2 demux.
module tb_four_bit_1x2_demux_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] In;
  logic       In_valid, In_ready, Select, Mode, Sync;
  logic [3:0] Out_0, Out_1;
  logic       Out_0_valid, Out_1_valid, Out_0_ack, Out_1_ack;
  logic [7:0] Count_0, Count_1;

  int vectors = 0;
  int errors  = 0;

  four_bit_1x2_demux_reg #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .In(In), .In_valid(In_valid), .In_ready(In_ready),
    .Select(Select), .Mode(Mode), .Sync(Sync),
    .Out_0(Out_0), .Out_0_valid(Out_0_valid), .Out_0_ack(Out_0_ack),
    .Out_1(Out_1), .Out_1_valid(Out_1_valid), .Out_1_ack(Out_1_ack),
    .Count_0(Count_0), .Count_1(Count_1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; In = 4'h0; In_valid = 1'b0; Select = 1'b0; Mode = 1'b0;
    Sync = 1'b0; Out_0_ack = 1'b0; Out_1_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; In = 4'hF; In_valid = 1'b1; Select = 1'b0; Mode = 1'b0;
    Sync = 1'b0; Out_0_ack = 1'b0; Out_1_ack = 1'b0;
    tick(); tick();
    vectors++;
    if ({Out_0, Out_1, Out_0_valid, Out_1_valid, Count_0, Count_1} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs got o0=%h o1=%h v0=%b v1=%b c0=%0d c1=%0d exp all 0",
               Out_0, Out_1, Out_0_valid, Out_1_valid, Count_0, Count_1);
    end
    rst_n = 1'b1; In_valid = 1'b0;
    #1;
    vectors++;
    if (In_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", In_ready);
    end
  endtask

  task automatic test_steered();
    do_reset();
    Mode = 1'b0; Select = 1'b1; In = 4'hA; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    vectors++;
    if (Out_1 !== 4'hA || Out_1_valid !== 1'b1 || Count_1 !== 8'd1) begin
      errors++;
      $display("FAIL steered_lane1 got o1=%h v1=%b c1=%0d exp A 1 1", Out_1, Out_1_valid, Count_1);
    end
    vectors++;
    if (Out_0 !== 4'h0 || Out_0_valid !== 1'b0 || Count_0 !== 8'd0) begin
      errors++;
      $display("FAIL steered_lane0 got o0=%h v0=%b c0=%0d exp 0 0 0", Out_0, Out_0_valid, Count_0);
    end
    Out_1_ack = 1'b1;
    tick();
    Out_1_ack = 1'b0;
    vectors++;
    if (Out_1_valid !== 1'b0 || Out_1 !== 4'hA) begin
      errors++;
      $display("FAIL ack_clears got v1=%b o1=%h exp 0 A", Out_1_valid, Out_1);
    end
  endtask

  task automatic test_alternating();
    logic [3:0] exp0 [4] = '{4'h1, 4'h1, 4'h3, 4'h3};
    logic [3:0] exp1 [4] = '{4'h0, 4'h2, 4'h2, 4'h4};
    do_reset();
    Mode = 1'b1; Out_0_ack = 1'b1; Out_1_ack = 1'b1; In_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      In = 4'(i + 1);
      tick();
      vectors++;
      if (Out_0 !== exp0[i] || Out_1 !== exp1[i]) begin
        errors++;
        $display("FAIL alt_step%0d got o0=%h o1=%h exp %h %h", i, Out_0, Out_1, exp0[i], exp1[i]);
      end
    end
    In_valid = 1'b0;
    vectors++;
    if (Count_0 !== 8'd2 || Count_1 !== 8'd2 || Out_1_valid !== 1'b1 || Out_0_valid !== 1'b0) begin
      errors++;
      $display("FAIL alt_counts got c0=%0d c1=%0d v0=%b v1=%b exp 2 2 0 1",
               Count_0, Count_1, Out_0_valid, Out_1_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    Mode = 1'b0; Select = 1'b0; In = 4'h5; In_valid = 1'b1;
    tick();
    In = 4'h6;
    #1;
    vectors++;
    if (In_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got ready=%b exp 0", In_ready);
    end
    tick();
    vectors++;
    if (Out_0 !== 4'h5 || Count_0 !== 8'd1) begin
      errors++; $display("FAIL bp_hold got o0=%h c0=%0d exp 5 1", Out_0, Count_0);
    end
    Out_0_ack = 1'b1;
    #1;
    vectors++;
    if (In_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ack_ready got ready=%b exp 1", In_ready);
    end
    tick();
    vectors++;
    if (Out_0 !== 4'h6 || Out_0_valid !== 1'b1 || Count_0 !== 8'd2) begin
      errors++;
      $display("FAIL bp_replace got o0=%h v0=%b c0=%0d exp 6 1 2", Out_0, Out_0_valid, Count_0);
    end
    // lane 0 full and unacked, lane 1 empty: target lane 1 must be ready
    Out_0_ack = 1'b0; In_valid = 1'b0; Select = 1'b1;
    #1;
    vectors++;
    if (In_ready !== 1'b1) begin
      errors++; $display("FAIL bp_other_lane got ready=%b exp 1", In_ready);
    end
  endtask

  task automatic test_sync();
    do_reset();
    Mode = 1'b1; Out_0_ack = 1'b1; Out_1_ack = 1'b1; In_valid = 1'b1;
    In = 4'h0;
    tick();
    In = 4'h7; Sync = 1'b1;
    tick();
    Sync = 1'b0;
    vectors++;
    if (Out_1 !== 4'h7 || Out_1_valid !== 1'b1) begin
      errors++; $display("FAIL sync_word got o1=%h v1=%b exp 7 1", Out_1, Out_1_valid);
    end
    In = 4'h8;
    tick();
    vectors++;
    if (Out_0 !== 4'h8 || Count_0 !== 8'd2 || Count_1 !== 8'd1) begin
      errors++;
      $display("FAIL sync_next got o0=%h c0=%0d c1=%0d exp 8 2 1", Out_0, Count_0, Count_1);
    end
    // pointer now EXPECT_1; a Mode=0 detour must not disturb it
    Mode = 1'b0; Select = 1'b0; In = 4'h9;
    tick();
    Mode = 1'b1; In = 4'hB;
    tick();
    In_valid = 1'b0;
    vectors++;
    if (Out_0 !== 4'h9 || Out_1 !== 4'hB || Count_0 !== 8'd3 || Count_1 !== 8'd2) begin
      errors++;
      $display("FAIL mode_switch got o0=%h o1=%h c0=%0d c1=%0d exp 9 B 3 2",
               Out_0, Out_1, Count_0, Count_1);
    end
  endtask

  task automatic test_dual_ack();
    do_reset();
    Mode = 1'b0; In_valid = 1'b1;
    Select = 1'b0; In = 4'h3; tick();
    Select = 1'b1; In = 4'hC; tick();
    In_valid = 1'b0; Out_0_ack = 1'b1; Out_1_ack = 1'b1;
    tick();
    vectors++;
    if (Out_0_valid !== 1'b0 || Out_1_valid !== 1'b0 || Out_0 !== 4'h3 || Out_1 !== 4'hC) begin
      errors++;
      $display("FAIL dual_ack got v0=%b v1=%b o0=%h o1=%h exp 0 0 3 C",
               Out_0_valid, Out_1_valid, Out_0, Out_1);
    end
    tick();
    Out_0_ack = 1'b0; Out_1_ack = 1'b0;
    vectors++;
    if (Out_0_valid !== 1'b0 || Count_0 !== 8'd1 || Count_1 !== 8'd1 || Out_1 !== 4'hC) begin
      errors++;
      $display("FAIL idle_ack got v0=%b c0=%0d c1=%0d o1=%h exp 0 1 1 C",
               Out_0_valid, Count_0, Count_1, Out_1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    Mode = 1'b0; Select = 1'b0; Out_0_ack = 1'b1; In_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      In = 4'(i);
      tick();
    end
    vectors++;
    if (Count_0 !== 8'd255) begin
      errors++; $display("FAIL wrap_255 got c0=%0d exp 255", Count_0);
    end
    In = 4'hF;
    tick();
    In_valid = 1'b0; Out_0_ack = 1'b0;
    vectors++;
    if (Count_0 !== 8'd0 || Count_1 !== 8'd0 || Out_0 !== 4'hF || Out_0_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_0 got c0=%0d c1=%0d o0=%h v0=%b exp 0 0 F 1",
               Count_0, Count_1, Out_0, Out_0_valid);
    end
  endtask

  initial begin
    test_reset();
    test_steered();
    test_alternating();
    test_backpressure();
    test_sync();
    test_dual_ack();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_1x2_demux_reg.md
Name: four_bit_1x2_demux_reg

Overview:
- Registered 1-to-2 demultiplexer; the receive-side counterpart of the 2x1 mux datapath.
- Accepts one WIDTH-bit word per handshake and steers it into one of two output lane registers.
- Lane is chosen by an explicit Select, or by an internal alternating pointer that de-interleaves a time-multiplexed stream.
- Each lane holds its word until the downstream consumer acknowledges it, and keeps a wrap-around count of accepted words.

Parameters:
- WIDTH, 4, data word width in bits
- CNT_WIDTH, 8, width of each per-lane accepted-word counter

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- In  input  WIDTH  input data word
- In_valid  input  1  source presents a valid word on In
- In_ready  output  1  block will accept In this cycle (combinational)
- Select  input  1  lane select when Mode=0 (0 -> lane 0, 1 -> lane 1)
- Mode  input  1  0 = Select-steered, 1 = alternating (pointer-steered)
- Sync  input  1  forces alternating pointer back to lane 0
- Out_0  output  WIDTH  lane 0 held word
- Out_0_valid  output  1  lane 0 holds an unacknowledged word
- Out_0_ack  input  1  consumer takes lane 0 word
- Out_1  output  WIDTH  lane 1 held word
- Out_1_valid  output  1  lane 1 holds an unacknowledged word
- Out_1_ack  input  1  consumer takes lane 1 word
- Count_0  output  CNT_WIDTH  words accepted into lane 0
- Count_1  output  CNT_WIDTH  words accepted into lane 1

Behaviour:
- Reset (rst_n=0 at a clock edge): Out_0, Out_1, Count_0, Count_1 = 0; both valids = 0; pointer = EXPECT_0. Reset overrides all other inputs in that cycle, including mid-handshake. A held word is discarded.
- Target lane: T = Mode ? pointer : Select. It is evaluated combinationally every cycle.
- In_ready = !Out_T_valid | Out_T_ack. It depends on the target lane only; the other lane's state is irrelevant.
- Accept = In_valid & In_ready. On accept:
  - Out_T <= In and Out_T_valid <= 1 at the next edge (latency 1 cycle).
  - Count_T increments by 1 and wraps from 2^CNT_WIDTH-1 to 0.
- Ack on a valid lane without an accept into that lane: valid <= 0, data held unchanged.
- Ack while the lane valid=0: ignored.
- Accept and ack to the same lane in the same cycle: new word replaces old, valid stays 1. This sustains full throughput (one word per cycle per lane).
- Non-accepted In_valid: no state change. The source holds In stable until accepted.
- Pointer FSM (two states: EXPECT_0, EXPECT_1):
  - It toggles only on an accept while Mode=1.
  - Sync=1 at an edge forces EXPECT_0 and wins over the toggle.
  - A word accepted in the same cycle as Sync goes to the pre-Sync pointer lane.
- Mode=0: pointer holds its value (Sync still applies).
- Mode change mid-stream takes effect immediately on T. The pointer is not reset by the Mode change.
- The two lanes are independent; acks to both lanes in one cycle are both honoured.

Decomposition:
- Shared package: WIDTH/CNT_WIDTH defaults, pointer state encoding (EXPECT_0=1'b0, EXPECT_1=1'b1), lane index constants LANE_0/LANE_1.
- Natural sub-module: demux_lane_reg, instantiated twice. It holds the data register, valid flag and counter for one lane, with inputs load, ack, d.
- The top level holds the target mux, In_ready and the pointer FSM.

Test Plan:
- Reset: drive In=4'hF, In_valid=1 with rst_n=0 for 2 cycles -> all outputs 0, In_ready=1 after release, pointer=EXPECT_0.
- Steered mode: Mode=0, Select=1, In=4'hA for 1 cycle -> next cycle Out_1=4'hA, Out_1_valid=1, Count_1=1; lane 0 unchanged.
- Alternating de-interleave: Mode=1, stream 4'h1,4'h2,4'h3,4'h4 over consecutive cycles with both acks held high -> lane 0 gets 1 then 3, lane 1 gets 2 then 4; Count_0=Count_1=2.
- Backpressure: Mode=0, Select=0, load 4'h5, hold Out_0_ack=0, present 4'h6 -> In_ready=0, Out_0 stays 4'h5. Assert ack -> 4'h6 accepted same cycle, Out_0=4'h6, valid stays 1.
- Sync collision: Mode=1, pointer at EXPECT_1, accept 4'h7 with Sync=1 -> Out_1=4'h7, next word 4'h8 lands in lane 0.
- Counter wrap: 256 accepts into lane 0 (CNT_WIDTH=8) -> Count_0 returns to 0; Count_1 unchanged.
